// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order retirement buffer for a SUPER-wide out-of-order core.
// Decode allocates up to SUPER entries per cycle at the tail. The
// reservation stations mark entries done by ROB index. Up to SUPER of the
// oldest contiguous done entries retire from the head each cycle.
//
// Parameters:
//   ROB_SZ  entry count (power of two, >= 2*SUPER)
//   SUPER   lanes for dispatch, completion and commit
//   PREG_W  physical destination tag width
//   IDX_W   derived ROB index width, clog2(ROB_SZ)
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           (only when ROB_FLUSH_EN is defined) discard all entries
//   alloc_valid     per-lane allocation request
//   alloc_dst       per-lane physical destination
//   alloc_idx       per-lane granted ROB index (combinational)
//   alloc_stall     fewer than SUPER free entries; nothing accepted
//   cmpl_valid      per-lane completion strobe
//   cmpl_idx        per-lane completing ROB index
//   commit_valid    in-order retire strobes, lane 0 is the oldest
//   commit_dst      per-lane retiring destination
//   count           registered occupancy
//
// Optional feature macro: ROB_FLUSH_EN (adds the flush port).
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_SZ = 16,
    parameter int SUPER  = 3,
    parameter int PREG_W = 6,
    localparam int IDX_W = $clog2(ROB_SZ)
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef ROB_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic [SUPER-1:0]          alloc_valid,
    input  logic [SUPER*PREG_W-1:0]   alloc_dst,
    output logic [SUPER*IDX_W-1:0]    alloc_idx,
    output logic                      alloc_stall,
    input  logic [SUPER-1:0]          cmpl_valid,
    input  logic [SUPER*IDX_W-1:0]    cmpl_idx,
    output logic [SUPER-1:0]          commit_valid,
    output logic [SUPER*PREG_W-1:0]   commit_dst,
    output logic [IDX_W:0]            count
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(ROB_SZ);
    localparam logic [IDX_W:0] LANES = (IDX_W+1)'(SUPER);
    localparam logic [IDX_W:0] ONE   = (IDX_W+1)'(1);

    logic [ROB_SZ-1:0] busy;
    logic [ROB_SZ-1:0] done;
    logic [PREG_W-1:0] dst_mem [ROB_SZ];
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [IDX_W:0]    cnt;

    logic [IDX_W:0]    n_alloc;
    logic [IDX_W:0]    n_commit;
    logic [SUPER-1:0]  grant;
    logic              flush_act;

`ifdef ROB_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign count = cnt;

    // Stall looks only at registered occupancy, so same-cycle commits never
    // feed back into the allocation decision.
    assign alloc_stall = (DEPTH - cnt) < LANES;

    // Allocation: lane i takes tail plus the number of valid lanes below it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional logic, otherwise a latch is inferred.
        n_alloc   = '0;
        alloc_idx = '0;
        for (int i = 0; i < SUPER; i++) begin
            alloc_idx[i*IDX_W +: IDX_W] = tail + n_alloc[IDX_W-1:0];
            // NOTE: blocking assignment is deliberate here; the running
            // total must be visible to the next loop iteration.
            if (alloc_valid[i]) n_alloc = n_alloc + ONE;
        end
        grant = alloc_valid;
        if (alloc_stall || flush_act) begin
            grant   = '0;
            n_alloc = '0;
        end
    end

    // Commit: a contiguous prefix of busy+done entries starting at head.
    always_comb begin : commit_chain
        logic ok;
        ok           = !flush_act;
        n_commit     = '0;
        commit_valid = '0;
        commit_dst   = '0;
        for (int k = 0; k < SUPER; k++) begin
            ok = ok && busy[head + IDX_W'(k)] && done[head + IDX_W'(k)];
            commit_valid[k] = ok;
            commit_dst[k*PREG_W +: PREG_W] = dst_mem[head + IDX_W'(k)];
            if (ok) n_commit = n_commit + ONE;
        end
    end

    // Control state. Later assignments in this block win, so completions
    // are applied first, then commit clears, then fresh allocations.
    // Allocated slots are always free (stall guarantees room), so the three
    // groups never touch the same entry in a conflicting way.
    always_ff @(posedge clk) begin
        if (rst || flush_act) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            busy <= '0;
            done <= '0;
        end else begin
            for (int i = 0; i < SUPER; i++) begin
                if (cmpl_valid[i] && busy[cmpl_idx[i*IDX_W +: IDX_W]])
                    done[cmpl_idx[i*IDX_W +: IDX_W]] <= 1'b1;
            end
            for (int k = 0; k < SUPER; k++) begin
                if (commit_valid[k]) begin
                    busy[head + IDX_W'(k)] <= 1'b0;
                    done[head + IDX_W'(k)] <= 1'b0;
                end
            end
            for (int i = 0; i < SUPER; i++) begin
                if (grant[i]) begin
                    busy[alloc_idx[i*IDX_W +: IDX_W]] <= 1'b1;
                    done[alloc_idx[i*IDX_W +: IDX_W]] <= 1'b0;
                end
            end
            head <= head + n_commit[IDX_W-1:0];
            tail <= tail + n_alloc[IDX_W-1:0];
            cnt  <= cnt + n_alloc - n_commit;
        end
    end

    // NOTE: the destination array has no reset; an entry's dst is only read
    // while its busy bit is set, and busy is always written with dst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SUPER; i++) begin
            if (grant[i])
                dst_mem[alloc_idx[i*IDX_W +: IDX_W]] <= alloc_dst[i*PREG_W +: PREG_W];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer (default parameters). A queue-based
// model tracks outstanding instructions in program order. The driver checks
// occupancy, stall, granted indices and commit strobes each cycle. A
// separate monitor pops expected destinations whenever the DUT retires.
// Flush scenarios are compiled in when ROB_FLUSH_EN is defined.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    localparam int ROB_SZ = 16;
    localparam int SUPER  = 3;
    localparam int PREG_W = 6;
    localparam int IDX_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [SUPER-1:0]        alloc_valid = '0;
    logic [SUPER*PREG_W-1:0] alloc_dst = '0;
    logic [SUPER*IDX_W-1:0]  alloc_idx;
    logic                    alloc_stall;
    logic [SUPER-1:0]        cmpl_valid = '0;
    logic [SUPER*IDX_W-1:0]  cmpl_idx = '0;
    logic [SUPER-1:0]        commit_valid;
    logic [SUPER*PREG_W-1:0] commit_dst;
    logic [IDX_W:0]          count;
`ifdef ROB_FLUSH_EN
    logic                    flush = 1'b0;
`endif

    reorder_buffer #(.ROB_SZ(ROB_SZ), .SUPER(SUPER), .PREG_W(PREG_W)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ROB_FLUSH_EN
        .flush        (flush),
`endif
        .alloc_valid  (alloc_valid),
        .alloc_dst    (alloc_dst),
        .alloc_idx    (alloc_idx),
        .alloc_stall  (alloc_stall),
        .cmpl_valid   (cmpl_valid),
        .cmpl_idx     (cmpl_idx),
        .commit_valid (commit_valid),
        .commit_dst   (commit_dst),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Program-order model of outstanding instructions.
    typedef struct {
        int idx;
        bit done;
    } ent_t;

    ent_t rob_q[$];
    int   m_tail = 0;
    int   exp_dst_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: each retiring lane must match the oldest expected dst.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int k = 0; k < SUPER; k++) begin
                    if (commit_valid[k] === 1'b1) begin
                        if (exp_dst_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL commit_dst lane %0d: retired dst %0d with nothing expected",
                                     k, commit_dst[k*PREG_W +: PREG_W]);
                        end else begin
                            check($sformatf("commit_dst lane %0d", k),
                                  32'(commit_dst[k*PREG_W +: PREG_W]), 32'(exp_dst_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        alloc_valid = '0;
        cmpl_valid  = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        rob_q.delete();
        exp_dst_q.delete();
        m_tail = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset count", 32'(count), 0);
        check("reset alloc_stall", 32'(alloc_stall), 0);
        check("reset commit_valid", 32'(commit_valid), 0);
    endtask

    // One cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic [SUPER-1:0] av, input logic [SUPER*PREG_W-1:0] adst,
                        input logic [SUPER-1:0] cv, input logic [SUPER*IDX_W-1:0] cidx,
                        input bit fl);
        int sz;
        bit stall;
        int below;
        int ncm;
        ent_t e;
        @(negedge clk);
        alloc_valid = av;
        alloc_dst   = adst;
        cmpl_valid  = cv;
        cmpl_idx    = cidx;
`ifdef ROB_FLUSH_EN
        flush = fl;
`endif
        #1;
        sz    = rob_q.size();
        stall = (ROB_SZ - sz) < SUPER;
        check("count", 32'(count), 32'(sz));
        check("alloc_stall", 32'(alloc_stall), 32'(stall));
        below = 0;
        for (int i = 0; i < SUPER; i++) begin
            if (av[i]) begin
                check($sformatf("alloc_idx lane %0d", i), 32'(alloc_idx[i*IDX_W +: IDX_W]),
                      32'((m_tail + below) % ROB_SZ));
                below++;
            end
        end
        ncm = 0;
        if (!fl)
            while (ncm < SUPER && ncm < sz && rob_q[ncm].done) ncm++;
        check("commit_valid", 32'(commit_valid), 32'((1 << ncm) - 1));

        if (fl) begin
            rob_q.delete();
            exp_dst_q.delete();
            m_tail = 0;
        end else begin
            repeat (ncm) void'(rob_q.pop_front());
            for (int i = 0; i < SUPER; i++) begin
                if (cv[i]) begin
                    foreach (rob_q[j])
                        if (rob_q[j].idx == int'(cidx[i*IDX_W +: IDX_W])) rob_q[j].done = 1'b1;
                end
            end
            if (!stall) begin
                for (int i = 0; i < SUPER; i++) begin
                    if (av[i]) begin
                        e.idx  = m_tail;
                        e.done = 1'b0;
                        rob_q.push_back(e);
                        exp_dst_q.push_back(int'(adst[i*PREG_W +: PREG_W]));
                        m_tail = (m_tail + 1) % ROB_SZ;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, '0, '0, 1'b0);
    endtask

    // Random cycle: completions mostly target outstanding entries.
    task automatic rand_step();
        logic [SUPER-1:0]        av;
        logic [SUPER*PREG_W-1:0] adst;
        logic [SUPER-1:0]        cv;
        logic [SUPER*IDX_W-1:0]  cidx;
        bit                      fl;
        av   = SUPER'($urandom);
        adst = (SUPER*PREG_W)'($urandom);
        cv   = SUPER'($urandom);
        cidx = '0;
        for (int i = 0; i < SUPER; i++) begin
            if (rob_q.size() > 0 && $urandom_range(0, 4) != 0)
                cidx[i*IDX_W +: IDX_W] = IDX_W'(rob_q[$urandom_range(0, rob_q.size() - 1)].idx);
            else
                cidx[i*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, ROB_SZ - 1));
        end
        fl = 1'b0;
`ifdef ROB_FLUSH_EN
        fl = ($urandom_range(0, 59) == 0);
`endif
        step(av, adst, cv, cidx, fl);
    endtask

    // Complete every outstanding entry and let the buffer empty (bounded).
    task automatic drain();
        logic [SUPER-1:0]       cv;
        logic [SUPER*IDX_W-1:0] cidx;
        int                     lane;
        int                     budget;
        budget = 200;
        while (rob_q.size() > 0 && budget > 0) begin
            cv   = '0;
            cidx = '0;
            lane = 0;
            foreach (rob_q[j]) begin
                if (!rob_q[j].done && lane < SUPER) begin
                    cv[lane] = 1'b1;
                    cidx[lane*IDX_W +: IDX_W] = IDX_W'(rob_q[j].idx);
                    lane++;
                end
            end
            step('0, '0, cv, cidx, 1'b0);
            budget--;
        end
        if (rob_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries still outstanding after cycle budget", rob_q.size());
        end
    endtask

    initial begin
        do_reset();

        // Sparse allocation: lanes 0 and 2 get indices 0 and 1.
        step(3'b101, {6'd33, 6'd20, 6'd11}, '0, '0, 1'b0);
        // Out-of-order completion: idx1 first, then idx0; retire both together.
        step('0, '0, 3'b001, 12'd1, 1'b0);
        step('0, '0, 3'b001, 12'd0, 1'b0);
        idle(2);

        // Completions to free entries change nothing.
        step('0, '0, 3'b111, {4'd9, 4'd5, 4'd2}, 1'b0);
        idle(2);

        // Fill to 14, then further requests stall and occupancy holds.
        do_reset();
        repeat (4) step(3'b111, (SUPER*PREG_W)'($urandom), '0, '0, 1'b0);
        step(3'b011, (SUPER*PREG_W)'($urandom), '0, '0, 1'b0);
        repeat (3) step(3'b111, (SUPER*PREG_W)'($urandom), '0, '0, 1'b0);
        drain();
        idle(2);

        // Pointer wrap: walk head/tail to 15, then allocate across the boundary.
        do_reset();
        for (int c = 0; c < 5; c++)
            step(3'b111, (SUPER*PREG_W)'($urandom), '0, '0, 1'b0);
        for (int c = 0; c < 5; c++)
            step('0, '0, 3'b111,
                 {IDX_W'(3*c + 2), IDX_W'(3*c + 1), IDX_W'(3*c)}, 1'b0);
        idle(4);
        step(3'b111, {6'd7, 6'd6, 6'd5}, '0, '0, 1'b0);
        step('0, '0, 3'b111, {4'd1, 4'd0, 4'd15}, 1'b0);
        idle(2);
        step(3'b001, {12'd0, 6'd42}, '0, '0, 1'b0);
        step('0, '0, 3'b001, 12'd2, 1'b0);
        idle(2);

`ifdef ROB_FLUSH_EN
        // Flush with 5 entries (some done) and an allocation pending.
        do_reset();
        step(3'b111, (SUPER*PREG_W)'($urandom), '0, '0, 1'b0);
        step(3'b011, (SUPER*PREG_W)'($urandom), 3'b011, {4'd0, 4'd1, 4'd0}, 1'b0);
        step(3'b111, (SUPER*PREG_W)'($urandom), 3'b001, 12'd2, 1'b1);
        idle(2);
`endif

        // Randomized traffic.
        do_reset();
        repeat (3000) rand_step();
        drain();
        idle(3);
        check("scoreboard empty", 32'(exp_dst_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
